// File: rtl/layer_4_fc.sv
// Fully-connected classifier: drains pooled words from the layer-3 RAM, MACs them against
// a synchronous weight ROM into N_OUT accumulators, then reports the argmax neuron.
module layer_4_fc #(
  parameter int N_FEAT = 32,
  parameter int N_OUT  = 10,
  parameter int W_W    = 8,
  parameter int ACC_W  = 36,
  parameter int DATA_W = 18,
  localparam int AW    = $clog2(N_FEAT * N_OUT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     strt,
  input  logic                     rd,
  input  logic [3:0][DATA_W-1:0]   din,
  input  logic [3:0][W_W-1:0]      w_data,
  output logic                     addr_rd_inc,
  output logic [AW-1:0]            w_addr,
  output logic                     busy,
  output logic                     tx_done,
  output logic [3:0]               class_out,
  output logic signed [ACC_W-1:0]  score_out,
  output logic                     valid
);

  localparam int FW = $clog2(N_FEAT);
  localparam int JW = $clog2(N_OUT);
  localparam int PW = DATA_W + W_W;
  localparam logic [FW-1:0] F_LAST = FW'(N_FEAT - 1);
  localparam logic [JW-1:0] J_LAST = JW'(N_OUT - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WAIT_RD = 3'd1;
  localparam logic [2:0] LATCH   = 3'd2;
  localparam logic [2:0] MAC     = 3'd3;
  localparam logic [2:0] DRAIN   = 3'd4;
  localparam logic [2:0] ARGMAX  = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;

  logic [2:0]               state;
  logic [FW-1:0]            feat_idx;
  logic [JW-1:0]            j;
  logic [3:0][DATA_W-1:0]   feat_p0;
  logic                     vld_p1;
  logic [JW-1:0]            mac_idx_p1;
  logic signed [ACC_W-1:0]  acc [N_OUT];
  logic signed [ACC_W-1:0]  best_val, win_val, cand;
  logic [JW-1:0]            best_idx, win_idx;

  // Four full-precision signed products, each sign-extended before summing.
  function automatic logic signed [ACC_W-1:0] dot4(input logic [3:0][DATA_W-1:0] f,
                                                    input logic [3:0][W_W-1:0] w);
    logic signed [ACC_W-1:0] s;
    logic signed [PW-1:0]    fe, we, p;
    s = '0;
    for (int c = 0; c < 4; c++) begin
      fe = PW'($signed(f[c]));
      we = PW'($signed(w[c]));
      p  = fe * we;
      s  = s + ACC_W'(p);
    end
    return s;
  endfunction

  assign busy        = (state != IDLE);
  assign tx_done     = (state == DONE);
  assign addr_rd_inc = (state == LATCH);

  always_comb begin
    cand    = acc[j];
    win_val = best_val;
    win_idx = best_idx;
    if (j == '0 || cand > best_val) begin
      win_val = cand;
      win_idx = j;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      feat_idx   <= '0;
      j          <= '0;
      w_addr     <= '0;
      vld_p1     <= 1'b0;
      mac_idx_p1 <= '0;
      class_out  <= '0;
      score_out  <= '0;
      valid      <= 1'b0;
      for (int i = 0; i < N_OUT; i++) acc[i] <= '0;
    end else begin
      // ---- stage p1: weight for the address issued last cycle is now on w_data
      vld_p1     <= (state == MAC);
      mac_idx_p1 <= j;
      if (vld_p1) acc[mac_idx_p1] <= acc[mac_idx_p1] + dot4(feat_p0, w_data);

      case (state)
        IDLE: if (strt) begin
          for (int i = 0; i < N_OUT; i++) acc[i] <= '0;
          feat_idx <= '0;
          valid    <= 1'b0;
          state    <= WAIT_RD;
        end
        WAIT_RD: if (rd) state <= LATCH;
        LATCH: begin
          w_addr <= AW'(feat_idx * N_OUT);
          j      <= '0;
          state  <= MAC;
        end
        MAC: begin
          if (j == J_LAST) begin
            j     <= '0;
            state <= DRAIN;
          end else begin
            j      <= j + 1'b1;
            w_addr <= w_addr + 1'b1;
          end
        end
        DRAIN: begin
          if (feat_idx == F_LAST) begin
            state <= ARGMAX;
          end else begin
            feat_idx <= feat_idx + 1'b1;
            state    <= WAIT_RD;
          end
        end
        ARGMAX: begin
          if (j == J_LAST) begin
            j         <= '0;
            class_out <= 4'(win_idx);
            score_out <= win_val;
            valid     <= 1'b1;
            state     <= DONE;
          end else begin
            j <= j + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // ---- stage p0: feature word capture and running argmax candidate
  always_ff @(posedge clk) begin
    if (state == LATCH) feat_p0 <= din;
    if (state == ARGMAX) begin
      best_val <= win_val;
      best_idx <= win_idx;
    end
  end

endmodule
